// File: rtl/rgmii_to_gmii.sv
// rgmii_to_gmii: RGMII receive front end. Captures DDR nibbles, strips preamble/SFD,
// checks FCS and length, and delivers framed bytes with per-frame status and counters.
//
// state    | meaning
// IDLE     | waiting for dv with 0x55 (preamble) or 0xD5 (short preamble)
// PREAMBLE | inside the 0x55 run, waiting for SFD
// DATA     | delivering frame bytes through the one-byte hold stage
// DROP     | discarding the rest of the burst until dv falls

module rgmii_rx_iddr (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_rxd,
  input  logic       i_ctrl,
  output logic [7:0] o_byte,
  output logic       o_dv,
  output logic       o_er
);
  logic [3:0] r_rise_d;
  logic [3:0] r_fall_d;
  logic       r_rise_c;
  logic       r_fall_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rise_d <= '0;
      r_rise_c <= 1'b0;
    end else begin
      r_rise_d <= i_rxd;
      r_rise_c <= i_ctrl;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_fall_d <= '0;
      r_fall_c <= 1'b0;
    end else begin
      r_fall_d <= i_rxd;
      r_fall_c <= i_ctrl;
    end
  end

  // Realign both halves of the cycle onto the rising edge, as the IDDR primitive does.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_byte <= '0;
      o_dv   <= 1'b0;
      o_er   <= 1'b0;
    end else begin
      o_byte <= {r_fall_d, r_rise_d};
      o_dv   <= r_rise_c;
      o_er   <= r_rise_c ^ r_fall_c;
    end
  end
endmodule

module rgmii_to_gmii #(
  parameter int MAX_LEN = 1522,
  parameter int MIN_LEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rgmii_rxd,
  input  logic        rgmii_rx_ctrl,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic        rx_err,
  output logic        rx_crc_ok,
  output logic [15:0] frame_count,
  output logic [15:0] err_count
);
  localparam logic [31:0] LP_POLY    = 32'hEDB88320;
  localparam logic [31:0] LP_RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] LP_MAX     = 11'(MAX_LEN);
  localparam logic [10:0] LP_MIN     = 11'(MIN_LEN);

  typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_DATA, ST_DROP} state_t;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] v;
    v = c;
    for (int i = 0; i < 8; i++) begin
      v = (v[0] ^ d[i]) ? ((v >> 1) ^ LP_POLY) : (v >> 1);
    end
    return v;
  endfunction

  logic [7:0]  w_q_byte;
  logic        w_q_dv;
  logic        w_q_er;
  logic [7:0]  r_st_byte;
  logic        r_st_dv;
  logic        r_st_er;
  state_t      r_state;
  state_t      w_state_nxt;
  logic [10:0] r_cnt;
  logic [10:0] w_cnt_inc;
  logic [31:0] r_crc;
  logic [31:0] w_crc_nxt;
  logic        r_er_seen;
  logic        w_emit;
  logic        w_last;
  logic        w_over;
  logic        w_eof;
  logic        w_crc_ok;
  logic        w_err;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_rx_sof;
  logic        r_rx_eof;
  logic        r_rx_err;
  logic        r_rx_crc_ok;
  logic [15:0] r_frame_count;
  logic [15:0] r_err_count;

  rgmii_rx_iddr u_iddr (
    .clk    (clk),
    .rst    (rst),
    .i_rxd  (rgmii_rxd),
    .i_ctrl (rgmii_rx_ctrl),
    .o_byte (w_q_byte),
    .o_dv   (w_q_dv),
    .o_er   (w_q_er)
  );

  // The stage register is the hold byte; the IDDR output is its successor, so the
  // eof decision is known when the held byte is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_st_byte <= '0;
      r_st_dv   <= 1'b0;
      r_st_er   <= 1'b0;
    end else begin
      r_st_byte <= w_q_byte;
      r_st_dv   <= w_q_dv;
      r_st_er   <= w_q_er;
    end
  end

  assign w_cnt_inc = (r_cnt == 11'h7FF) ? r_cnt : r_cnt + 11'd1;
  assign w_crc_nxt = crc_step(r_crc, r_st_byte);
  assign w_last    = ~w_q_dv;
  assign w_over    = w_q_dv & (w_cnt_inc == LP_MAX);
  assign w_eof     = w_last | w_over;
  assign w_crc_ok  = w_last & (w_crc_nxt == LP_RESIDUE);
  assign w_err     = w_over | ~w_crc_ok | r_er_seen | r_st_er | (w_cnt_inc < LP_MIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_st_dv) begin
          if (r_st_byte == 8'h55)      w_state_nxt = ST_PREAMBLE;
          else if (r_st_byte == 8'hD5) w_state_nxt = ST_DATA;
          else                         w_state_nxt = ST_DROP;
        end
      end
      ST_PREAMBLE: begin
        if (!r_st_dv)                w_state_nxt = ST_IDLE;
        else if (r_st_byte == 8'h55) w_state_nxt = ST_PREAMBLE;
        else if (r_st_byte == 8'hD5) w_state_nxt = ST_DATA;
        else                         w_state_nxt = ST_DROP;
      end
      ST_DATA: begin
        if (!r_st_dv) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_emit = 1'b1;
          if (w_last)      w_state_nxt = ST_IDLE;
          else if (w_over) w_state_nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        if (!r_st_dv) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_crc     <= '1;
      r_er_seen <= 1'b0;
    end else if (w_emit && !w_eof) begin
      r_cnt     <= w_cnt_inc;
      r_crc     <= w_crc_nxt;
      r_er_seen <= r_er_seen | r_st_er;
    end else if (w_emit || r_state != ST_DATA) begin
      r_cnt     <= '0;
      r_crc     <= '1;
      r_er_seen <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_rx_sof      <= 1'b0;
      r_rx_eof      <= 1'b0;
      r_rx_err      <= 1'b0;
      r_rx_crc_ok   <= 1'b0;
      r_frame_count <= '0;
      r_err_count   <= '0;
    end else begin
      r_rx_data   <= w_emit ? r_st_byte : 8'h00;
      r_rx_valid  <= w_emit;
      r_rx_sof    <= w_emit & (r_cnt == 11'd0);
      r_rx_eof    <= w_emit & w_eof;
      r_rx_err    <= w_emit & w_eof & w_err;
      r_rx_crc_ok <= w_emit & w_eof & w_crc_ok;
      if (w_emit && w_eof) begin
        r_frame_count <= r_frame_count + 16'd1;
        if (w_err) r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign rx_sof      = r_rx_sof;
  assign rx_eof      = r_rx_eof;
  assign rx_err      = r_rx_err;
  assign rx_crc_ok   = r_rx_crc_ok;
  assign frame_count = r_frame_count;
  assign err_count   = r_err_count;
endmodule

// File: tb/tb_rgmii_to_gmii.sv
// tb_rgmii_to_gmii: drives RGMII DDR bursts and compares every delivered byte and the
// counters against a burst-level reference model.
module tb_rgmii_to_gmii;
  localparam int MAX_LEN = 1522;
  localparam int MIN_LEN = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  rgmii_rxd = '0;
  logic        rgmii_rx_ctrl = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sof, rx_eof, rx_err, rx_crc_ok;
  logic [15:0] frame_count, err_count;

  rgmii_to_gmii #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .rgmii_rxd     (rgmii_rxd),
    .rgmii_rx_ctrl (rgmii_rx_ctrl),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_sof        (rx_sof),
    .rx_eof        (rx_eof),
    .rx_err        (rx_err),
    .rx_crc_ok     (rx_crc_ok),
    .frame_count   (frame_count),
    .err_count     (err_count)
  );

  always #4 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] c;
    logic [7:0]  d;
    logic        sof;
    logic        eof;
    logic        err;
    logic        ok;
  } rec_t;

  rec_t        obs_q[$];
  rec_t        exp_q[$];
  logic [7:0]  st_b[$];
  logic        st_dv[$];
  logic        st_er[$];
  int unsigned st_c[$];
  logic [7:0]  frm[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          exp_frames = 0;
  int          exp_errs = 0;
  rec_t        mon_r;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && rx_valid) begin
      mon_r.c   = cyc;
      mon_r.d   = rx_data;
      mon_r.sof = rx_sof;
      mon_r.eof = rx_eof;
      mon_r.err = rx_err;
      mon_r.ok  = rx_crc_ok;
      obs_q.push_back(mon_r);
    end
  end

  // One RXC period: low nibble/dv before the rising edge, high nibble/dv^er before the falling.
  task automatic send_cycle(input logic [7:0] b, input logic dv, input logic er);
    @(negedge clk); #1;
    rgmii_rxd = b[3:0];
    rgmii_rx_ctrl = dv;
    @(posedge clk); #1;
    rgmii_rxd = b[7:4];
    rgmii_rx_ctrl = dv ^ er;
    st_b.push_back(b);
    st_dv.push_back(dv);
    st_er.push_back(er);
    st_c.push_back(cyc);
  endtask

  function automatic logic [31:0] fcs_of_frm(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, frm[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic logic [31:0] fcs_of_stim(input int s, input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = s; i < s + n; i++) begin
      c = c ^ {24'h0, st_b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_frame(input int n, input bit avoid_pre);
    logic [7:0]  b;
    logic [31:0] f;
    frm.delete();
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      if (avoid_pre && (b == 8'h55 || b == 8'hD5)) b = b ^ 8'h01;
      frm.push_back(b);
    end
    f = fcs_of_frm(n);
    frm.push_back(f[7:0]);
    frm.push_back(f[15:8]);
    frm.push_back(f[23:16]);
    frm.push_back(f[31:24]);
  endtask

  task automatic send_frame(input int pre, input int er_idx, input int gap);
    repeat (pre) send_cycle(8'h55, 1'b1, 1'b0);
    send_cycle(8'hD5, 1'b1, 1'b0);
    foreach (frm[i]) send_cycle(frm[i], 1'b1, i == er_idx);
    repeat (gap) send_cycle(8'h00, 1'b0, 1'b0);
  endtask

  // Burst-level model: a dv run is a frame iff it is (0x55)* 0xD5 followed by data.
  task automatic model_check(input string tag);
    int   i, k, p, s, len, ne, e0;
    logic over, ok, er_any, err;
    logic [31:0] rx_fcs;
    rec_t r;
    repeat (8) send_cycle(8'h00, 1'b0, 1'b0);
    exp_q.delete();
    i = 0;
    while (i < st_b.size()) begin
      if (!st_dv[i]) begin
        i++;
      end else begin
        k = i;
        while (k < st_b.size() && st_dv[k]) k++;
        p = i;
        while (p < k && st_b[p] == 8'h55) p++;
        if (p < k && st_b[p] == 8'hD5) begin
          s    = p + 1;
          len  = k - s;
          over = (len > MAX_LEN);
          ne   = over ? MAX_LEN : len;
          ok   = 1'b0;
          if (!over && len >= 4) begin
            rx_fcs = {st_b[k-1], st_b[k-2], st_b[k-3], st_b[k-4]};
            ok = (fcs_of_stim(s, len - 4) == rx_fcs);
          end
          er_any = 1'b0;
          for (int j = s; j < k; j++) er_any |= st_er[j];
          err = over || !ok || er_any || (len < MIN_LEN);
          for (int j = 0; j < ne; j++) begin
            r.c   = st_c[s+j] + 3;
            r.d   = st_b[s+j];
            r.sof = (j == 0);
            r.eof = (j == ne - 1);
            r.err = (j == ne - 1) && err;
            r.ok  = (j == ne - 1) && ok;
            exp_q.push_back(r);
          end
          if (ne > 0) begin
            exp_frames++;
            if (err) exp_errs++;
          end
        end
        i = k;
      end
    end
    check({tag, "_nbytes"}, 64'(obs_q.size()), 64'(exp_q.size()));
    e0 = n_err;
    for (int j = 0; j < obs_q.size() && j < exp_q.size(); j++) begin
      check($sformatf("%s_byte%0d", tag, j), 64'(obs_q[j]), 64'(exp_q[j]));
      if (n_err > e0 + 3) break;
    end
    check({tag, "_frame_count"}, 64'(frame_count), 64'(exp_frames[15:0]));
    check({tag, "_err_count"}, 64'(err_count), 64'(exp_errs[15:0]));
    obs_q.delete();
    st_b.delete();
    st_dv.delete();
    st_er.delete();
    st_c.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pre, len, gap, idx;
    logic [7:0] b1;
    repeat (3) @(negedge clk);
    check("reset_outs", {rx_valid, rx_sof, rx_eof, rx_err, rx_crc_ok, rx_data, frame_count, err_count}, 64'd0);
    #1 rst = 1'b1;
    repeat (2) send_cycle(8'h00, 1'b0, 1'b0);
    check("idle_crc_reg", 64'(dut.r_crc), 64'hFFFFFFFF);

    build_frame(60, 1'b0);
    send_frame(7, -1, 2);
    model_check("good64");

    frm[10][0] = ~frm[10][0];
    send_frame(7, -1, 2);
    model_check("badcrc");

    build_frame(36, 1'b0);
    send_frame(7, -1, 2);
    model_check("runt40");

    build_frame(1596, 1'b0);
    send_frame(7, -1, 2);
    build_frame(60, 1'b0);
    send_frame(3, -1, 2);
    model_check("oversize");

    build_frame(60, 1'b0);
    send_frame(7, 20, 2);
    send_cycle(8'h55, 1'b1, 1'b0);
    send_cycle(8'h55, 1'b1, 1'b0);
    send_cycle(8'h5D, 1'b1, 1'b0);
    repeat (20) send_cycle(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    send_cycle(8'h00, 1'b0, 1'b0);
    send_cycle(8'h3C, 1'b0, 1'b1);
    model_check("er_badpre");

    frm.delete();
    frm.push_back(8'h00);
    send_frame(7, -1, 1);
    build_frame(70, 1'b0);
    send_frame(7, -1, 1);
    build_frame(61, 1'b0);
    send_frame(0, -1, 1);
    model_check("b2b_1byte");

    for (int n = 0; n < 12; n++) begin
      pre = $urandom_range(0, 7);
      len = $urandom_range(40, 150);
      gap = $urandom_range(1, 3);
      build_frame(len, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, len + 3);
        b1 = frm[idx];
        b1[$urandom_range(0, 7)] ^= 1'b1;
        frm[idx] = b1;
      end
      idx = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len + 3) : -1;
      send_frame(pre, idx, gap);
    end
    model_check("random");

    build_frame(60, 1'b1);
    repeat (7) send_cycle(8'h55, 1'b1, 1'b0);
    send_cycle(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) send_cycle(frm[i], 1'b1, 1'b0);
    @(negedge clk); #2;
    check("pre_rst_valid", 64'(rx_valid), 64'd1);
    rst = 1'b0;
    #1;
    check("midrst_outs", {rx_valid, rx_sof, rx_eof, rx_err, rx_crc_ok, rx_data, frame_count, err_count}, 64'd0);
    send_cycle(frm[30], 1'b1, 1'b0);
    rst = 1'b1;
    obs_q.delete();
    st_b.delete();
    st_dv.delete();
    st_er.delete();
    st_c.delete();
    exp_frames = 0;
    exp_errs = 0;
    for (int i = 31; i < frm.size(); i++) send_cycle(frm[i], 1'b1, 1'b0);
    send_cycle(8'h00, 1'b0, 1'b0);
    model_check("rst_drop");
    build_frame(60, 1'b0);
    send_frame(7, -1, 2);
    model_check("after_rst");
    check("after_rst_fc1", 64'(frame_count), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/rgmii_to_gmii.md
# rgmii_to_gmii

Receive-side counterpart of the RGMII transmit path. It captures the PHY's DDR receive nibbles, reassembles bytes, strips preamble/SFD, and checks FCS and length. It delivers each frame as a byte stream with start/end markers and a per-frame status, plus frame and error counters. It sits between the RGMII RX pins and the MAC receive logic, clocked by the PHY receive clock.

## Interface
- MAX_LEN, 1522: maximum frame length in bytes, DA through FCS inclusive.
- MIN_LEN, 64: minimum frame length in bytes, DA through FCS inclusive.
- clk  input  1  PHY RX clock (RGMII RXC), 125 MHz; sole clock.
- rst  input  1  asynchronous, active-low reset.
- rgmii_rxd  input  4  DDR data; low nibble on rising edge, high nibble on falling edge.
- rgmii_rx_ctrl  input  1  DDR control; RX_DV on rising edge, RX_DV XOR RX_ER on falling edge.
- rx_data  output  8  received byte (SFD and preamble excluded, FCS included).
- rx_valid  output  1  rx_data valid this cycle.
- rx_sof  output  1  first byte after SFD; qualified by rx_valid.
- rx_eof  output  1  last byte of frame; qualified by rx_valid.
- rx_err  output  1  frame bad; valid only with rx_eof.
- rx_crc_ok  output  1  FCS residue correct; valid only with rx_eof.
- frame_count  output  16  frames delivered (every rx_eof), wraps.
- err_count  output  16  frames delivered with rx_err=1, wraps.

## Operation
- Capture: one IDDRX1F per pin (SCLK=clk, RST=~rst). Per cycle this yields byte = {fall_nibble, rise_nibble}, dv = rise_ctrl, er = rise_ctrl ^ fall_ctrl.
- States: IDLE, PREAMBLE, DATA, DROP.
- IDLE:
  - dv=1 and byte=0x55 -> PREAMBLE.
  - dv=1 and byte=0xD5 -> DATA (short preamble accepted).
  - dv=1 and any other byte -> DROP.
  - dv=0 -> stay; er with dv=0 (false carrier/extension) is ignored.
- PREAMBLE:
  - 0x55 -> stay.
  - 0xD5 -> DATA.
  - other byte -> DROP.
  - dv=0 -> IDLE; nothing emitted.
- DATA: each byte enters a one-byte hold register. A held byte is released when the next capture cycle arrives.
  - Next cycle has dv=1: release the held byte normally.
  - Next cycle has dv=0: release the held byte with rx_eof=1, then -> IDLE.
  - First released byte carries rx_sof=1.
- Byte counter counts DATA bytes, 11 bits, saturating.
- Oversize: when the (MAX_LEN+1)th byte arrives, the held MAX_LEN-th byte is released with rx_eof=1 and rx_err=1, then -> DROP.
- DROP: emits nothing; -> IDLE when dv=0.
- CRC-32: reflected, polynomial 0xEDB88320, init 0xFFFFFFFF, updated on every DATA byte including FCS. rx_crc_ok = (register == 0xDEBB20E3) at end of frame.
- rx_err = ~rx_crc_ok OR er seen in any DATA cycle (sticky per frame) OR count < MIN_LEN OR oversize. The CRC term is not evaluated on an oversize cut; that case is err=1 and crc_ok=0.
- Counters: frame_count +1 on each rx_eof. err_count +1 on each rx_eof with rx_err=1. Both wrap at 0xFFFF.

## Timing
- Reset (rst=0): immediately, all outputs 0, counters 0, state IDLE, hold register empty, CRC register 0xFFFFFFFF.
- Latency: a byte sampled on the edges of cycle N appears on rx_data in cycle N+3 (1 IDDR, 1 stage register, 1 hold). This is constant for every byte, including the rx_eof byte.
- rx_valid carries no backpressure. Back-to-back frames with a 1-cycle dv-low gap must be handled, with sof/eof never merged.
- rx_sof and rx_eof are in the same cycle only if the frame has 1 byte; that frame is a runt, err=1.
- Reset released mid-frame: the remaining bytes (not 0x55/0xD5) send IDLE -> DROP; nothing is emitted until the next preamble.
- All status outputs are registered; no combinational path from inputs to outputs.

## Test plan
- 64-byte frame (7x0x55, 0xD5, 60 data bytes, correct FCS) -> 64 rx_valid cycles; sof on the first, eof on the 64th; crc_ok=1, err=0, frame_count=1, err_count=0; first byte out 3 cycles after the first DATA sample.
- Same frame with bit 0 of data byte 10 flipped -> eof with crc_ok=0, err=1, err_count=1.
- 40-byte frame with valid FCS -> crc_ok=1 and err=1 (runt).
- 1600-byte burst -> exactly 1522 bytes out, eof on byte 1522 with err=1; no further valid until dv falls and a new preamble arrives.
- er=1 (falling-edge ctrl=0 while rising=1) on byte 20 -> err=1 at eof. Preamble 0x55,0x55,0x5D -> no output; state returns to IDLE at dv low.
- rst pulsed low during byte 30 of a frame -> outputs 0 at once, nothing emitted for the rest of that frame; the next good frame is delivered normally and frame_count=1.
